// File: rtl/mod_arith_pkg.sv
// -----------------------------------------------------------------------------
// mod_arith_pkg
// Shared definitions for the modular arithmetic datapath: the add/sub opcode,
// default widths and the Dilithium modulus. The stage-1 record type depends on
// the coefficient width, so it is declared inside each module that uses it.
// -----------------------------------------------------------------------------
package mod_arith_pkg;

   // Per-transaction operation select.
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Default coefficient/modulus width and sideband tag width.
   localparam int unsigned W_DEFAULT     = 23;
   localparam int unsigned TAG_W_DEFAULT = 4;

   // Dilithium prime, q = 2^23 - 2^13 + 1; fits in W_DEFAULT bits.
   localparam int unsigned Q_DILITHIUM   = 8380417;

endpackage : mod_arith_pkg

// File: rtl/mod_reduce_once.sv
// -----------------------------------------------------------------------------
// mod_reduce_once
// Purely combinational single-step correction of a raw W+1 bit add/sub result
// into the range [0, q). Shared with the butterfly datapath.
//
// Ports
//   i_raw  in  W+1  raw result: {0,a}+{0,b} for ADD, {0,a}-{0,b} for SUB
//   i_q    in  W    modulus
//   i_op   in  op_e operation that produced i_raw
//   o_c    out W    corrected result
//
// ADD: one conditional subtraction of q (valid while a,b < q, so r < 2q).
// SUB: bit W of the raw result is the borrow; when set, add q back and keep
//      the low W bits, which wraps the negative difference into range.
// -----------------------------------------------------------------------------
module mod_reduce_once
   import mod_arith_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic [W:0]   i_raw,
   input  logic [W-1:0] i_q,
   input  op_e          i_op,
   output logic [W-1:0] o_c
);

   logic [W:0]   w_q_ext;
   logic         w_ge_q;
   logic [W-1:0] w_sub_q;
   logic [W-1:0] w_add_q;

   assign w_q_ext = {1'b0, i_q};
   assign w_ge_q  = (i_raw >= w_q_ext);

   // When r >= q the true difference fits in W bits, so the low W bits of a
   // W-bit subtraction are exact; the top bit of r drops out harmlessly.
   assign w_sub_q = i_raw[W-1:0] - i_q;

   // Borrow case: r[W-1:0] is (a-b) mod 2^W; adding q mod 2^W lands on a-b+q.
   assign w_add_q = i_raw[W-1:0] + i_q;

   always_comb begin
      o_c = i_raw[W-1:0];
      case (i_op)
         OP_ADD: begin
            if (w_ge_q) begin
               o_c = w_sub_q;
            end
         end
         OP_SUB: begin
            if (i_raw[W]) begin
               o_c = w_add_q;
            end
         end
         default: o_c = i_raw[W-1:0];
      endcase
   end

endmodule : mod_reduce_once

// File: rtl/mod_addsub_pipe.sv
// -----------------------------------------------------------------------------
// mod_addsub_pipe
// Two-stage pipelined modular adder/subtractor with a valid/ready stream on
// both sides. c = (a + b) mod q or (a - b) mod q, with op, q and a sideband tag
// carried per transaction so every field may change on every input beat.
//
// Ports
//   clk_i    in  1      clock, rising edge
//   rst_i    in  1      synchronous reset, active-high
//   valid_i  in  1      input beat valid
//   ready_o  out 1      input beat can be taken this cycle
//   op_i     in  1      OP_ADD=0 / OP_SUB=1
//   a_i      in  W      operand a, expected < q_i
//   b_i      in  W      operand b, expected < q_i
//   q_i      in  W      modulus for this beat
//   tag_i    in  TAG_W  opaque tag, returned with the result
//   valid_o  out 1      result valid
//   ready_i  in  1      downstream takes the result this cycle
//   c_o      out W      result
//   tag_o    out TAG_W  tag belonging to c_o
//
// Stage 1 registers the raw W+1 bit sum/difference together with q, op and
// tag. Stage 2 registers the corrected result and drives the outputs.
// Each stage advances when it is empty or the stage after it advances, so the
// ready chain is combinational from ready_i and a full pipe keeps streaming at
// one beat per cycle. valid_o comes straight from a flop.
// -----------------------------------------------------------------------------
module mod_addsub_pipe
   import mod_arith_pkg::*;
#(
   parameter int unsigned W     = W_DEFAULT,
   parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             op_i,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic [W-1:0]     q_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [W-1:0]     c_o,
   output logic [TAG_W-1:0] tag_o
);

   // Stage-1 record: raw result is one bit wider than the operands so the
   // ADD carry and the SUB borrow both survive into stage 2.
   typedef struct packed {
      logic [W:0]       raw;
      logic [W-1:0]     q;
      op_e              op;
      logic [TAG_W-1:0] tag;
   } s1_t;

   // ---------------------------------------------------------------- state
   s1_t              r_s1;
   logic             r_v1;
   logic             r_v2;
   logic [W-1:0]     r_c;
   logic [TAG_W-1:0] r_tag;

   // ---------------------------------------------------------------- wires
   op_e              w_op;
   logic [W:0]       w_a_ext;
   logic [W:0]       w_b_ext;
   logic [W:0]       w_raw;
   s1_t              w_s1_next;
   logic [W-1:0]     w_c;
   logic             w_adv1;
   logic             w_adv2;

   // ------------------------------------------------------- stage enables
   // A stage may load when it is empty or when its contents move on.
   assign w_adv2  = !r_v2 || ready_i;
   assign w_adv1  = !r_v1 || w_adv2;
   assign ready_o = w_adv1;

   // ------------------------------------------------ stage-1 arithmetic
   assign w_op    = op_e'(op_i);
   assign w_a_ext = {1'b0, a_i};
   assign w_b_ext = {1'b0, b_i};
   assign w_raw   = (w_op == OP_SUB) ? (w_a_ext - w_b_ext)
                                     : (w_a_ext + w_b_ext);

   assign w_s1_next = '{raw: w_raw, q: q_i, op: w_op, tag: tag_i};

   // ------------------------------------------------ stage-2 correction
   mod_reduce_once #(
      .W (W)
   ) u_reduce (
      .i_raw (r_s1.raw),
      .i_q   (r_s1.q),
      .i_op  (r_s1.op),
      .o_c   (w_c)
   );

   // ---------------------------------------------------------- registers
   // Payload registers only load on a valid beat so that stalled or idle
   // stages keep their contents; the output payload in particular must hold
   // steady while valid_o waits for ready_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_s1  <= '0;
         r_c   <= '0;
         r_tag <= '0;
      end else begin
         if (w_adv1) begin
            r_v1 <= valid_i;
            if (valid_i) begin
               r_s1 <= w_s1_next;
            end
         end
         if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_c   <= w_c;
               r_tag <= r_s1.tag;
            end
         end
      end
   end

   // ------------------------------------------------------------ outputs
   assign valid_o = r_v2;
   assign c_o     = r_c;
   assign tag_o   = r_tag;

endmodule : mod_addsub_pipe

// File: tb/tb_mod_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_mod_addsub_pipe
// Directed and streaming checks of mod_addsub_pipe at W=23 plus an exhaustive
// sweep at W=8, q=251 split over four small instances (op x half of a-range).
// -----------------------------------------------------------------------------
module tb_mod_addsub_pipe;
   import mod_arith_pkg::*;

   localparam int W  = 23;
   localparam int TW = 4;
   localparam int unsigned QD   = Q_DILITHIUM;
   localparam int unsigned QMAX = 8388607;
   localparam int unsigned Q8   = 251;
   localparam int          HALF = 126;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i;
   logic          ready_o;
   logic          op_i;
   logic [W-1:0]  a_i;
   logic [W-1:0]  b_i;
   logic [W-1:0]  q_i;
   logic [TW-1:0] tag_i;
   logic          valid_o;
   logic          ready_i;
   logic [W-1:0]  c_o;
   logic [TW-1:0] tag_o;

   always #5 clk = ~clk;

   mod_addsub_pipe #(.W(W), .TAG_W(TW)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .q_i     (q_i),
      .tag_i   (tag_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .c_o     (c_o),
      .tag_o   (tag_o)
   );

   // Exhaustive W=8 instances: index bit 0 = op, bit 1 = upper half of a.
   logic       e_valid_i [4];
   logic       e_ready_o [4];
   logic       e_op      [4];
   logic [7:0] e_a       [4];
   logic [7:0] e_b       [4];
   logic       e_valid_o [4];
   logic [7:0] e_c       [4];
   logic [3:0] e_tag_o   [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_exh
         mod_addsub_pipe #(.W(8), .TAG_W(4)) u_exh (
            .clk_i   (clk),
            .rst_i   (rst),
            .valid_i (e_valid_i[gi]),
            .ready_o (e_ready_o[gi]),
            .op_i    (e_op[gi]),
            .a_i     (e_a[gi]),
            .b_i     (e_b[gi]),
            .q_i     (8'd251),
            .tag_i   (4'(gi)),
            .valid_o (e_valid_o[gi]),
            .ready_i (1'b1),
            .c_o     (e_c[gi]),
            .tag_o   (e_tag_o[gi])
         );
      end
   endgenerate

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   // Reference: plain integer (a +/- b) mod q for in-contract operands.
   function automatic longint gold(input logic op, input longint a, input longint b,
                                   input longint q);
      longint r;
      if (!op) begin
         r = a + b;
         if (r >= q) r = r - q;
      end else begin
         r = a - b;
         if (r < 0) r = r + q;
      end
      return r;
   endfunction

   // Single isolated transaction; entered and left on a negedge.
   task automatic run_one(input string nm, input logic op, input int unsigned a,
                          input int unsigned b, input int unsigned q,
                          input logic [3:0] tg, input int unsigned exp);
      chk({nm, "_rdy"}, 64'(ready_o), 64'(1));
      valid_i = 1'b1; op_i = op; a_i = W'(a); b_i = W'(b); q_i = W'(q); tag_i = tg;
      @(posedge clk); @(negedge clk);
      valid_i = 1'b0;
      chk({nm, "_lat1"}, 64'(valid_o), 64'(0));
      @(posedge clk); @(negedge clk);
      chk({nm, "_v"},   64'(valid_o), 64'(1));
      chk({nm, "_c"},   64'(c_o),     64'(exp));
      chk({nm, "_tag"}, 64'(tag_o),   64'(tg));
      $display("txn %s op=%0d a=%0d b=%0d q=%0d -> c=%0d tag=%0d", nm, op, a, b, q, c_o, tag_o);
   endtask

   int unsigned s_q [100];
   int unsigned s_a [100];
   int unsigned s_b [100];
   logic        s_op[100];
   longint      s_e [100];
   int unsigned bp_e[5];
   logic        hist_v [2][4];
   logic [7:0]  hist_c [2][4];

   initial begin
      rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; op_i = 1'b0;
      a_i = '0; b_i = '0; q_i = W'(QD); tag_i = '0;
      for (int g = 0; g < 4; g++) begin
         e_valid_i[g] = 1'b0; e_op[g] = 1'b0; e_a[g] = '0; e_b[g] = '0;
         hist_v[0][g] = 1'b0; hist_v[1][g] = 1'b0; hist_c[0][g] = '0; hist_c[1][g] = '0;
      end

      // ---- reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 64'(valid_o), 64'(0));
      chk("rst_c",     64'(c_o),     64'(0));
      chk("rst_tag",   64'(tag_o),   64'(0));
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("rst_ready", 64'(ready_o), 64'(1));

      // ---- directed vectors (expected values hand-computed)
      run_one("add_basic", 1'b0, 5,       8380410, QD,   4'd3,  8380415);
      run_one("add_2q-2",  1'b0, 8380416, 8380416, QD,   4'd4,  8380415);
      run_one("add_eq_q",  1'b0, 4190208, 4190209, QD,   4'd5,  0);
      run_one("sub_neg",   1'b1, 3,       5,       QD,   4'd6,  8380415);
      run_one("sub_eq",    1'b1, 1234,    1234,    QD,   4'd7,  0);
      run_one("sub_0_qm1", 1'b1, 0,       8380416, QD,   4'd8,  1);
      run_one("add_q2",    1'b0, 1,       1,       2,    4'd9,  0);
      run_one("add_qmax",  1'b0, 8388606, 8388606, QMAX, 4'd10, 8388605);
      run_one("sub_qmax",  1'b1, 0,       8388606, QMAX, 4'd11, 1);
      run_one("sub_nobor", 1'b1, 8388606, 0,       QMAX, 4'd12, 8388606);
      run_one("add_ooc",   1'b0, 200,     50,      100,  4'd13, 150);
      run_one("sub_ooc",   1'b1, 10,      200,     100,  4'd14, 8388518);

      // ---- back-to-back random stream, mixed q
      for (int i = 0; i < 100; i++) begin
         s_q[i]  = $urandom_range(QMAX, 2);
         s_a[i]  = $urandom_range(s_q[i] - 1, 0);
         s_b[i]  = $urandom_range(s_q[i] - 1, 0);
         s_op[i] = 1'($urandom_range(1, 0));
         s_e[i]  = gold(s_op[i], s_a[i], s_b[i], s_q[i]);
      end
      for (int k = 0; k < 102; k++) begin
         if (k < 100) begin
            chk("stream_rdy", 64'(ready_o), 64'(1));
            valid_i = 1'b1; op_i = s_op[k]; a_i = W'(s_a[k]); b_i = W'(s_b[k]);
            q_i = W'(s_q[k]); tag_i = 4'(k % 16);
         end else begin
            valid_i = 1'b0;
         end
         if (k >= 2) begin
            chk("stream_v",   64'(valid_o), 64'(1));
            chk("stream_c",   64'(c_o),     64'(s_e[k-2]));
            chk("stream_tag", 64'(tag_o),   64'((k - 2) % 16));
            $display("txn stream[%0d] c=%0d exp=%0d tag=%0d", k - 2, c_o, s_e[k-2], tag_o);
         end
         @(posedge clk); @(negedge clk);
      end
      chk("stream_empty", 64'(valid_o), 64'(0));

      // ---- backpressure: downstream stalled for 5 cycles, source keeps offering
      begin
         int acc;
         int got;
         logic took;
         acc = 0;
         ready_i = 1'b0;
         for (int i = 0; i < 5; i++) bp_e[i] = 107 + i;
         for (int c = 0; c < 5; c++) begin
            valid_i = 1'b1; op_i = 1'b0; a_i = W'(100 + acc); b_i = W'(7);
            q_i = W'(QD); tag_i = 4'(8 + acc);
            if (c >= 2) begin
               chk("bp_rdy_low", 64'(ready_o), 64'(0));
               chk("bp_hold_v",  64'(valid_o), 64'(1));
               chk("bp_hold_c",  64'(c_o),     64'(bp_e[0]));
               chk("bp_hold_t",  64'(tag_o),   64'(8));
            end
            took = ready_o;
            @(posedge clk);
            if (took) acc++;
            @(negedge clk);
         end
         chk("bp_accepted", 64'(acc), 64'(2));
         valid_i = 1'b0;
         ready_i = 1'b1;
         got = 0;
         for (int k = 0; k < 8; k++) begin
            if (valid_o) begin
               if (got < 2) begin
                  chk("bp_drain_c", 64'(c_o),   64'(bp_e[got]));
                  chk("bp_drain_t", 64'(tag_o), 64'(8 + got));
               end
               $display("txn drain[%0d] c=%0d tag=%0d", got, c_o, tag_o);
               got++;
            end
            @(posedge clk); @(negedge clk);
         end
         chk("bp_drained", 64'(got), 64'(2));
      end

      // ---- reset with two transactions in flight
      ready_i = 1'b0;
      valid_i = 1'b1; op_i = 1'b0; a_i = W'(1); b_i = W'(2); q_i = W'(QD); tag_i = 4'd5;
      @(posedge clk); @(negedge clk);
      op_i = 1'b1; a_i = W'(9); b_i = W'(4); tag_i = 4'd6;
      @(posedge clk); @(negedge clk);
      chk("flush_pre_v", 64'(valid_o), 64'(1));
      valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      ready_i = 1'b1;
      chk("flush_v",   64'(valid_o), 64'(0));
      chk("flush_c",   64'(c_o),     64'(0));
      chk("flush_tag", 64'(tag_o),   64'(0));
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); @(negedge clk);
         chk("flush_quiet", 64'(valid_o), 64'(0));
      end
      $display("txn flush done");

      // ---- exhaustive W=8, q=251, both ops, four instances in parallel
      for (int t = 0; t < HALF * 251 + 2; t++) begin
         int i;
         int b;
         int slot;
         i    = t / 251;
         b    = t % 251;
         slot = t % 2;
         for (int g = 0; g < 4; g++) begin
            int   a;
            logic op;
            logic v;
            op = 1'(g & 1);
            a  = i + (g >> 1) * HALF;
            v  = (t < HALF * 251) && (a < 251);
            // Output now belongs to the beat driven two cycles ago.
            if (t >= 2) begin
               if (hist_v[slot][g]) begin
                  chk("exh", 64'({e_ready_o[g], e_valid_o[g], e_tag_o[g], e_c[g]}),
                             64'({1'b1, 1'b1, 4'(g), hist_c[slot][g]}));
               end else begin
                  chk("exh_idle", 64'(e_valid_o[g]), 64'(0));
               end
            end
            e_valid_i[g] = v;
            e_op[g]      = op;
            e_a[g]       = 8'(a);
            e_b[g]       = 8'(b);
            hist_v[slot][g] = v;
            hist_c[slot][g] = v ? 8'(gold(op, a, b, Q8)) : 8'd0;
         end
         @(posedge clk); @(negedge clk);
      end
      $display("txn exhaustive W=8 q=251 sweep done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mod_addsub_pipe
